// File: rtl/xpb_pkg.sv
// -----------------------------------------------------------------------------
// xpb_pkg
// Shared definitions for the runtime XPB table generator.
//   XPB_DIGIT_BITS : default lookup index width (table depth 2^XPB_DIGIT_BITS)
//   XPB_WORD_BITS  : default width of modulus, base and every table entry
//   xpb_state_e    : generator FSM states
//   xpb_idx_t      : table index type for the default digit width
// -----------------------------------------------------------------------------
package xpb_pkg;

  localparam int XPB_DIGIT_BITS = 5;
  localparam int XPB_WORD_BITS  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_FIN  = 2'd2
  } xpb_state_e;

  typedef logic [XPB_DIGIT_BITS-1:0] xpb_idx_t;

endpackage

// File: rtl/xpb_mod_add.sv
// -----------------------------------------------------------------------------
// xpb_mod_add
// Combinational modular adder: sum_o = (a_i + b_i) mod m_i, for a_i, b_i < m_i.
// Ports:
//   a_i, b_i : addends, both already reduced below m_i
//   m_i      : modulus, may use the full W bits
//   sum_o    : reduced sum
// -----------------------------------------------------------------------------
module xpb_mod_add #(
  parameter int W = 1024
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] sum_o
);

  logic [W:0] sum_s;

  // Add at W+1 bits so the carry joins the compare; a modulus filling all W
  // bits would otherwise let an overflowed sum slip through unreduced. The
  // subtraction can stay at W bits because the reduced result is below m_i.
  always_comb begin
    sum_s = {1'b0, a_i} + {1'b0, b_i};
    if (sum_s >= {1'b0, m_i}) begin
      sum_o = sum_s[W-1:0] - m_i;
    end else begin
      sum_o = sum_s[W-1:0];
    end
  end

endmodule

// File: rtl/xpb_lut_gen.sv
// -----------------------------------------------------------------------------
// xpb_lut_gen
// Fills a 2^DIGIT_BITS-entry table with entry[k] = k*B mod M (one entry per
// cycle, iterative modular addition) and serves registered lookups from it.
// entry[0] is never stored; lookups of digit 0 return zero.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cfg_start             : start request, accepted only in IDLE
//   cfg_modulus, cfg_base : M and B, sampled on the accept cycle
//   busy, done            : generation in progress / one-cycle completion pulse
//   cfg_err               : sticky, set by a start with B >= M
//   table_valid           : table holds a complete set of entries
//   rd_en, rd_digit       : lookup request and index
//   rd_valid, rd_data     : registered lookup response (zero unless valid table)
// Optional feature (macro XPB_LUT_DUAL_READ_EN): second independent read port
//   rd1_en, rd1_digit, rd1_valid, rd1_data with identical behaviour.
// -----------------------------------------------------------------------------
module xpb_lut_gen
  import xpb_pkg::*;
#(
  parameter int DIGIT_BITS = XPB_DIGIT_BITS,
  parameter int WORD_BITS  = XPB_WORD_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [WORD_BITS-1:0]  cfg_modulus,
  input  logic [WORD_BITS-1:0]  cfg_base,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  table_valid,
  input  logic                  rd_en,
  input  logic [DIGIT_BITS-1:0] rd_digit,
  output logic                  rd_valid,
`ifdef XPB_LUT_DUAL_READ_EN
  output logic [WORD_BITS-1:0]  rd_data,
  input  logic                  rd1_en,
  input  logic [DIGIT_BITS-1:0] rd1_digit,
  output logic                  rd1_valid,
  output logic [WORD_BITS-1:0]  rd1_data
`else
  output logic [WORD_BITS-1:0]  rd_data
`endif
);

  localparam int DEPTH = 1 << DIGIT_BITS;

  xpb_state_e            state_q;
  logic [WORD_BITS-1:0]  m_q;
  logic [WORD_BITS-1:0]  b_q;
  logic [WORD_BITS-1:0]  acc_q;
  logic [WORD_BITS-1:0]  acc_d;
  logic [DIGIT_BITS-1:0] k_q;
  logic [WORD_BITS-1:0]  mem_q [DEPTH];

  xpb_mod_add #(.W(WORD_BITS)) u_mod_add (
    .a_i   (acc_q),
    .b_i   (b_q),
    .m_i   (m_q),
    .sum_o (acc_d)
  );

  // Generator FSM with its status outputs and the accumulator datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      table_valid <= 1'b0;
      m_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      k_q         <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            m_q         <= cfg_modulus;
            b_q         <= cfg_base;
            acc_q       <= '0;
            k_q         <= DIGIT_BITS'(1);
            table_valid <= 1'b0;
            if (cfg_base >= cfg_modulus) begin
              // Reject: the adder assumes B < M, so no entries are written.
              cfg_err <= 1'b1;
            end else begin
              cfg_err <= 1'b0;
              busy    <= 1'b1;
              state_q <= ST_GEN;
            end
          end
        end
        ST_GEN: begin
          acc_q <= acc_d;
          k_q   <= k_q + DIGIT_BITS'(1);
          if (k_q == {DIGIT_BITS{1'b1}}) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            table_valid <= 1'b1;
            state_q     <= ST_FIN;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Table write port: entry k receives the freshly reduced accumulator.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_GEN) begin
      mem_q[k_q] <= acc_d;
    end
  end

  // Read port 0: zero unless the table is complete; digit 0 is hardwired zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (table_valid && rd_digit != '0) begin
          rd_data <= mem_q[rd_digit];
        end else begin
          rd_data <= '0;
        end
      end
    end
  end

`ifdef XPB_LUT_DUAL_READ_EN
  // Read port 1: identical gating to port 0, fully independent.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd1_valid <= 1'b0;
      rd1_data  <= '0;
    end else begin
      rd1_valid <= rd1_en;
      if (rd1_en) begin
        if (table_valid && rd1_digit != '0) begin
          rd1_data <= mem_q[rd1_digit];
        end else begin
          rd1_data <= '0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_xpb_lut_gen.sv
// -----------------------------------------------------------------------------
// tb_xpb_lut_gen
// Self-checking bench: a 16-bit instance covers timing, gating, bad config,
// abort and randomized fills; a default 1024-bit instance covers the carry
// case. Expected entries come from k*B mod M computed directly.
// -----------------------------------------------------------------------------
module tb_xpb_lut_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Small instance signals
  logic        s_start;
  logic [15:0] s_mod, s_base;
  logic        s_busy, s_done, s_err, s_tv;
  logic        s_rd_en;
  logic [4:0]  s_rd_digit;
  logic        s_rd_valid;
  logic [15:0] s_rd_data;
`ifdef XPB_LUT_DUAL_READ_EN
  logic        s_rd1_en;
  logic [4:0]  s_rd1_digit;
  logic        s_rd1_valid;
  logic [15:0] s_rd1_data;
`endif

  // Large instance signals
  logic          b_start;
  logic [1023:0] b_mod, b_base;
  logic          b_busy, b_done, b_err, b_tv;
  logic          b_rd_en;
  logic [4:0]    b_rd_digit;
  logic          b_rd_valid;
  logic [1023:0] b_rd_data;
`ifdef XPB_LUT_DUAL_READ_EN
  logic          b_rd1_en;
  logic [4:0]    b_rd1_digit;
  logic          b_rd1_valid;
  logic [1023:0] b_rd1_data;
`endif

  xpb_lut_gen #(.DIGIT_BITS(5), .WORD_BITS(16)) u_small (
    .clk         (clk),
    .reset       (reset),
    .cfg_start   (s_start),
    .cfg_modulus (s_mod),
    .cfg_base    (s_base),
    .busy        (s_busy),
    .done        (s_done),
    .cfg_err     (s_err),
    .table_valid (s_tv),
    .rd_en       (s_rd_en),
    .rd_digit    (s_rd_digit),
    .rd_valid    (s_rd_valid),
`ifdef XPB_LUT_DUAL_READ_EN
    .rd_data     (s_rd_data),
    .rd1_en      (s_rd1_en),
    .rd1_digit   (s_rd1_digit),
    .rd1_valid   (s_rd1_valid),
    .rd1_data    (s_rd1_data)
`else
    .rd_data     (s_rd_data)
`endif
  );

  xpb_lut_gen u_big (
    .clk         (clk),
    .reset       (reset),
    .cfg_start   (b_start),
    .cfg_modulus (b_mod),
    .cfg_base    (b_base),
    .busy        (b_busy),
    .done        (b_done),
    .cfg_err     (b_err),
    .table_valid (b_tv),
    .rd_en       (b_rd_en),
    .rd_digit    (b_rd_digit),
    .rd_valid    (b_rd_valid),
`ifdef XPB_LUT_DUAL_READ_EN
    .rd_data     (b_rd_data),
    .rd1_en      (b_rd1_en),
    .rd1_digit   (b_rd1_digit),
    .rd1_valid   (b_rd1_valid),
    .rd1_data    (b_rd1_data)
`else
    .rd_data     (b_rd_data)
`endif
  );

  // Reference model: entry[k] = k*B mod M by direct multiplication.
  function automatic logic [15:0] ref16(input logic [15:0] m, input logic [15:0] b, input int k);
    longint unsigned p;
    p = longint'(k) * longint'(b);
    return 16'(p % longint'(m));
  endfunction

  function automatic logic [1023:0] ref_big(input logic [1023:0] m, input logic [1023:0] b, input int k);
    logic [1039:0] p;
    p = {16'd0, b} * 1040'(k);
    p = p % {16'd0, m};
    return p[1023:0];
  endfunction

  function automatic logic [1023:0] rand_big();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a small-instance fill and check the whole generation window.
  task automatic run_gen(input logic [15:0] m, input logic [15:0] b);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    s_mod = m; s_base = b; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (s_busy === 1'b1) busy_cnt++;
      if (s_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i == 2) begin
        n_checks++;
        if (s_rd_valid !== 1'b1 || s_rd_data !== 16'h0) $display("FAIL gen_read_gated got valid=%0b data=%h want valid=1 data=0000", s_rd_valid, s_rd_data);
        else n_pass++;
      end
      if (i > 1 && done_at == i - 1) begin
        n_checks++;
        if (s_rd_valid !== 1'b1 || s_rd_data !== ref16(m, b, 31)) $display("FAIL fin_read got %h want %h", s_rd_data, ref16(m, b, 31));
        else n_pass++;
        n_checks++;
        if (s_busy !== 1'b0) $display("FAIL start_in_fin_ignored got busy=%0b want 0", s_busy);
        else n_pass++;
      end
      s_rd_en = 1'b0; s_start = 1'b0;
      if (i == 1) begin s_rd_en = 1'b1; s_rd_digit = 5'd16; end
      if (i == 5) begin s_start = 1'b1; s_base = b ^ 16'h5a5a; end
      if (s_done === 1'b1) begin s_rd_en = 1'b1; s_rd_digit = 5'd31; s_start = 1'b1; end
      tick();
    end
    s_rd_en = 1'b0; s_start = 1'b0;
    n_checks++;
    if (busy_cnt != 31) $display("FAIL busy_cycles got %0d want 31", busy_cnt);
    else n_pass++;
    n_checks++;
    if (done_at != 32 || done_cnt != 1) $display("FAIL done_timing got at=%0d count=%0d want at=32 count=1", done_at, done_cnt);
    else n_pass++;
    n_checks++;
    if (s_tv !== 1'b1 || s_err !== 1'b0) $display("FAIL post_gen_status got tv=%0b err=%0b want tv=1 err=0", s_tv, s_err);
    else n_pass++;
  endtask

  // One read on the small instance, then check that rd_data holds.
  task automatic rd_check(input logic [4:0] d, input logic [15:0] exp);
    s_rd_en = 1'b1; s_rd_digit = d;
    tick();
    s_rd_en = 1'b0; s_rd_digit = ~d;
    n_checks++;
    if (s_rd_valid !== 1'b1 || s_rd_data !== exp) $display("FAIL read_d%0d got valid=%0b data=%h want valid=1 data=%h", d, s_rd_valid, s_rd_data, exp);
    else n_pass++;
    tick();
    n_checks++;
    if (s_rd_valid !== 1'b0 || s_rd_data !== exp) $display("FAIL hold_d%0d got valid=%0b data=%h want valid=0 data=%h", d, s_rd_valid, s_rd_data, exp);
    else n_pass++;
  endtask

  task automatic big_gen(input logic [1023:0] m, input logic [1023:0] b);
    int done_at = -1;
    b_mod = m; b_base = b; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 1; i <= 40 && done_at < 0; i++) begin
      if (b_done === 1'b1) done_at = i;
      else tick();
    end
    n_checks++;
    if (done_at != 32 || b_tv !== 1'b1) $display("FAIL big_done got at=%0d tv=%0b want at=32 tv=1", done_at, b_tv);
    else n_pass++;
    tick();
  endtask

  task automatic big_read(input logic [4:0] d, input logic [1023:0] exp);
    b_rd_en = 1'b1; b_rd_digit = d;
    tick();
    b_rd_en = 1'b0;
    n_checks++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== exp) $display("FAIL big_read_d%0d got low64=%h want low64=%h", d, b_rd_data[63:0], exp[63:0]);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0 || s_err !== 1'b0 || s_tv !== 1'b0 || s_rd_valid !== 1'b0 || s_rd_data !== 16'h0)
      $display("FAIL reset_state got busy=%0b done=%0b err=%0b tv=%0b rv=%0b rd=%h want all 0", s_busy, s_done, s_err, s_tv, s_rd_valid, s_rd_data);
    else n_pass++;
    n_checks++;
    if (b_busy !== 1'b0 || b_tv !== 1'b0 || b_rd_data !== 1024'h0) $display("FAIL big_reset_state got busy=%0b tv=%0b want 0", b_busy, b_tv);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_small_fill();
    run_gen(16'hFFF1, 16'h1000);
    rd_check(5'd1,  ref16(16'hFFF1, 16'h1000, 1));
    rd_check(5'd15, ref16(16'hFFF1, 16'h1000, 15));
    rd_check(5'd16, ref16(16'hFFF1, 16'h1000, 16));
    rd_check(5'd17, ref16(16'hFFF1, 16'h1000, 17));
    rd_check(5'd31, ref16(16'hFFF1, 16'h1000, 31));
    rd_check(5'd0,  16'h0000);
  endtask

`ifdef XPB_LUT_DUAL_READ_EN
  task automatic test_dual_read();
    s_rd_en = 1'b1; s_rd_digit = 5'd1; s_rd1_en = 1'b1; s_rd1_digit = 5'd31;
    tick();
    n_checks++;
    if (s_rd_data !== ref16(16'hFFF1, 16'h1000, 1) || s_rd1_data !== ref16(16'hFFF1, 16'h1000, 31) || s_rd1_valid !== 1'b1)
      $display("FAIL dual_read got p0=%h p1=%h v1=%0b", s_rd_data, s_rd1_data, s_rd1_valid);
    else n_pass++;
    s_rd_digit = 5'd17; s_rd1_digit = 5'd17;
    tick();
    s_rd_en = 1'b0; s_rd1_en = 1'b0;
    n_checks++;
    if (s_rd_data !== ref16(16'hFFF1, 16'h1000, 17) || s_rd1_data !== ref16(16'hFFF1, 16'h1000, 17))
      $display("FAIL dual_same_digit got p0=%h p1=%h want %h", s_rd_data, s_rd1_data, ref16(16'hFFF1, 16'h1000, 17));
    else n_pass++;
    tick();
  endtask
`endif

  task automatic test_bad_config();
    int busy_seen = 0;
    s_mod = 16'h0100; s_base = 16'h0100; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    n_checks++;
    if (s_err !== 1'b1 || s_tv !== 1'b0) $display("FAIL bad_cfg_status got err=%0b tv=%0b want err=1 tv=0", s_err, s_tv);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (s_busy !== 1'b0) busy_seen++;
      tick();
    end
    n_checks++;
    if (busy_seen != 0) $display("FAIL bad_cfg_busy got %0d busy cycles want 0", busy_seen);
    else n_pass++;
    rd_check(5'd5, 16'h0000);
    run_gen(16'h0100, 16'h0001);
    rd_check(5'd31, ref16(16'h0100, 16'h0001, 31));
  endtask

  task automatic test_abort();
    int done_seen = 0;
    s_mod = 16'hFFF1; s_base = 16'h0003; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0 || s_tv !== 1'b0) $display("FAIL abort_status got busy=%0b done=%0b tv=%0b want 0", s_busy, s_done, s_tv);
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      if (s_done === 1'b1 || s_busy === 1'b1) done_seen++;
      tick();
    end
    n_checks++;
    if (done_seen != 0) $display("FAIL abort_no_done got %0d active cycles want 0", done_seen);
    else n_pass++;
    rd_check(5'd31, 16'h0000);
    run_gen(16'hFFF1, 16'h0003);
    rd_check(5'd31, ref16(16'hFFF1, 16'h0003, 31));
    rd_check(5'd10, ref16(16'hFFF1, 16'h0003, 10));
  endtask

  task automatic test_random_small();
    logic [15:0] m, b;
    logic [4:0]  d;
    for (int c = 0; c < 4; c++) begin
      m = 16'($urandom_range(65535, 2));
      if (c == 0) m = 16'hFFFF;
      b = 16'($urandom % m);
      run_gen(m, b);
      for (int r = 0; r < 5; r++) begin
        d = 5'($urandom_range(31, 0));
        rd_check(d, ref16(m, b, int'(d)));
      end
    end
  endtask

  task automatic test_big_carry();
    logic [1023:0] m, b;
    logic [4:0]    d;
    m = '1;
    b = m - 1024'd1;
    big_gen(m, b);
    big_read(5'd2,  ref_big(m, b, 2));
    big_read(5'd31, ref_big(m, b, 31));
    big_read(5'd17, ref_big(m, b, 17));
    m = rand_big();
    m[1023] = 1'b1;
    b = rand_big() % m;
    big_gen(m, b);
    for (int r = 0; r < 4; r++) begin
      d = 5'($urandom_range(31, 1));
      big_read(d, ref_big(m, b, int'(d)));
    end
  endtask

  initial begin
    reset = 1'b1;
    s_start = 1'b0; s_mod = '0; s_base = '0; s_rd_en = 1'b0; s_rd_digit = '0;
    b_start = 1'b0; b_mod = '0; b_base = '0; b_rd_en = 1'b0; b_rd_digit = '0;
`ifdef XPB_LUT_DUAL_READ_EN
    s_rd1_en = 1'b0; s_rd1_digit = '0; b_rd1_en = 1'b0; b_rd1_digit = '0;
`endif
    test_reset();
    test_small_fill();
`ifdef XPB_LUT_DUAL_READ_EN
    test_dual_read();
`endif
    test_bad_config();
    test_abort();
    test_random_small();
    test_big_carry();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule
